// File: rtl/irrigation_actuator_driver.sv
// irrigation_actuator_driver: sequences the valves and the shared pump from a 2-bit mode code.
// The valve opens before the pump, the pump runs a minimum time, and the pump stops before the valve closes.
module irrigation_actuator_driver #(
    parameter int SETTLE_CYC  = 4,
    parameter int MIN_RUN_CYC = 8,
    parameter int DRAIN_CYC   = 3,
    parameter int CNT_W       = 8
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [1:0] mode,
    output logic       valve_asp,
    output logic       valve_got,
    output logic       pump,
    output logic [1:0] active,
    output logic       busy,
    output logic       err
);
    typedef enum logic [1:0] {IDLE, OPEN, RUN, STOP} state_t;

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] RUN_LD    = CNT_W'(MIN_RUN_CYC - 1);
    localparam logic [CNT_W-1:0] DRAIN_LD  = CNT_W'(DRAIN_CYC - 1);

    state_t           state, state_n;
    logic [1:0]       target, target_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            target <= 2'b00;
            cnt    <= '0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            target <= target_n;
            cnt    <= cnt_n;
            err    <= err | (mode == 2'b11);
        end
    end

    always_comb begin
        state_n  = state;
        target_n = target;
        cnt_n    = (cnt != '0) ? cnt - 1'b1 : cnt;
        case (state)
            IDLE: begin
                cnt_n = cnt;
                if (mode == 2'b10 || mode == 2'b01) begin
                    state_n  = OPEN;
                    target_n = mode;
                    cnt_n    = SETTLE_LD;
                end
            end
            OPEN: if (cnt == '0) begin
                state_n = RUN;
                cnt_n   = RUN_LD;
            end
            // Requests made early are honoured only if still present once the minimum run expires
            RUN: if (cnt == '0 && mode != target && mode != 2'b11) begin
                state_n = STOP;
                cnt_n   = DRAIN_LD;
            end
            STOP: if (cnt == '0) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign valve_asp = (state != IDLE) && (target == 2'b10);
    assign valve_got = (state != IDLE) && (target == 2'b01);
    assign pump      = (state == RUN);
    assign active    = pump ? target : 2'b00;
    assign busy      = (state == OPEN) || (state == STOP);
endmodule

// File: tb/tb_irrigation_actuator_driver.sv
// tb_irrigation_actuator_driver: directed checks of valve/pump sequencing, err stickiness and async reset.
module tb_irrigation_actuator_driver;
    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] mode = 2'b00;
    logic       valve_asp, valve_got, pump, busy, err;
    logic [1:0] active;
    logic [6:0] outs;
    int         n_tests = 0;
    int         n_fail  = 0;

    irrigation_actuator_driver dut (
        .CLK(CLK), .reset(reset), .mode(mode),
        .valve_asp(valve_asp), .valve_got(valve_got), .pump(pump),
        .active(active), .busy(busy), .err(err)
    );

    always #5 CLK = ~CLK;

    // outs = {valve_asp, valve_got, pump, active, busy, err}
    assign outs = {valve_asp, valve_got, pump, active, busy, err};

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK)
        if (!reset) check("invariant", {5'b0, valve_asp & valve_got, pump & ~(valve_asp ^ valve_got)}, 7'b0);

    initial begin
        #12;
        check("reset_outs", outs, 7'b0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_mode00", outs, 7'b0);
        end
        // ASP start: valve first, pump 4 edges later
        mode = 2'b10;
        tick();
        check("asp_open", outs, 7'b1000010);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("asp_settle", outs, 7'b1000010);
        end
        tick();
        check("asp_run", outs, 7'b1011000);
        // early GOT request held until minimum run expires
        tick();
        tick();
        mode = 2'b01;
        for (int i = 3; i < 8; i++) begin
            tick();
            check("asp_minrun", outs, 7'b1011000);
        end
        tick();
        check("asp_stop", outs, 7'b1000010);
        tick();
        tick();
        check("asp_drain", outs, 7'b1000010);
        tick();
        check("gap_idle", outs, 7'b0);
        tick();
        check("got_open", outs, 7'b0100010);
        for (int i = 0; i < 3; i++) tick();
        check("got_settle", outs, 7'b0100010);
        tick();
        check("got_run", outs, 7'b0110100);
        // invalid code in RUN: only err reacts
        mode = 2'b11;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("run_mode11", outs, 7'b0110101);
        end
        mode = 2'b01;
        tick();
        check("err_sticky_run", outs, 7'b0110101);
        mode = 2'b00;
        tick();
        check("got_stop", outs, 7'b0100011);
        for (int i = 0; i < 3; i++) tick();
        check("got_idle", outs, 7'b0000001);
        // async reset in the middle of OPEN
        mode = 2'b10;
        tick();
        tick();
        check("pre_reset_open", outs, 7'b1000011);
        #2 reset = 1'b1;
        #1;
        check("async_reset", outs, 7'b0);
        mode = 2'b00;
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_reset_idle", outs, 7'b0);
        end
        // invalid code in IDLE
        mode = 2'b11;
        tick();
        check("idle_mode11", outs, 7'b0000001);
        mode = 2'b00;
        tick();
        check("err_sticky_idle", outs, 7'b0000001);
        // mode toggling during STOP is ignored; one IDLE cycle before reopening
        mode = 2'b10;
        for (int i = 0; i < 5; i++) tick();
        check("asp2_run", outs, 7'b1011001);
        mode = 2'b00;
        for (int i = 0; i < 8; i++) tick();
        check("asp2_stop", outs, 7'b1000011);
        mode = 2'b10;
        tick();
        check("stop_toggle1", outs, 7'b1000011);
        mode = 2'b00;
        tick();
        check("stop_toggle2", outs, 7'b1000011);
        mode = 2'b10;
        tick();
        check("asp2_idle", outs, 7'b0000001);
        tick();
        check("asp3_open", outs, 7'b1000011);
        for (int i = 0; i < 3; i++) tick();
        check("asp3_settle", outs, 7'b1000011);
        tick();
        check("asp3_run", outs, 7'b1011001);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
